mac_dot_ctrl: RTL and testbench
===============================

# mac_dot_ctrl

Sequencer that drives one registered multiply-accumulate unit (`data_out <= a*b + tmp`, one-cycle latency, synchronous reset) through a dot product of length `len`. Operand vectors come from two synchronous-read memories with one-cycle read latency. The accumulation feedback is routed through `mac_tmp`. The finished sum is presented on a valid/ready result port. The block sits between the layer-level scheduler (start/len/base addresses) and the shared MAC datapath of the CNN accelerator.

## Interface
- dataWidth, 16, operand/accumulator width (matches MAC)
- addrWidth, 8, operand memory address width
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new dot product; sampled only in IDLE
- len  in  addrWidth+1  element count, 0..2^addrWidth; latched on accepted start
- base_a  in  addrWidth  start address of vector A; latched on accepted start
- base_b  in  addrWidth  start address of vector B; latched on accepted start
- busy  out  1  high in every state except IDLE
- rd_en  out  1  read strobe to both operand memories
- addr_a  out  addrWidth  read address, memory A
- addr_b  out  addrWidth  read address, memory B
- rdata_a  in  dataWidth  memory A data, valid the cycle after rd_en
- rdata_b  in  dataWidth  memory B data, valid the cycle after rd_en
- mac_rst  out  1  MAC synchronous clear
- mac_ce  out  1  high when a real operand pair is presented to the MAC
- mac_a  out  dataWidth  MAC operand a
- mac_b  out  dataWidth  MAC operand b
- mac_tmp  out  dataWidth  MAC addend (accumulator feedback)
- mac_out  in  dataWidth  MAC registered output
- result  out  dataWidth  dot-product result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE: if start=1, latch len/base_a/base_b, clear index counter, then go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): mac_rst=1, no read. Next state is RUN if len>0, else FLUSH.
- RUN: rd_en=1, addr_a=base_a+idx, addr_b=base_b+idx, idx increments each cycle. After the cycle with idx=len-1, go to FLUSH.
- FLUSH (1 cycle): last operand pair (if any) reaches the MAC. Then go to DONE.
- DONE: result_valid=1. On result_valid & result_ready, go to IDLE.
- d_vld is a register equal to rd_en delayed one cycle.
- mac_a = d_vld ? rdata_a : 0. mac_b = d_vld ? rdata_b : 0. mac_ce = d_vld.
- mac_tmp = mac_out in all states. With zero operands the MAC therefore holds its value, because it has no functional enable.
- mac_rst = rst | (state==CLEAR).
- result = mac_out.
- Arithmetic: product and sum are truncated modulo 2^dataWidth, with no saturation. Addresses wrap modulo 2^addrWidth.
- start is ignored outside IDLE. len/base changes after acceptance have no effect.

## Timing
- Accepted start at edge E0. CLEAR occupies cycle C1, RUN occupies C2..C(len+1), FLUSH occupies C(len+2), and result_valid rises in C(len+3).
- Latency from start to result_valid is len+3 cycles for every len, including len=0.
- Read for element i is issued in C(i+2). The operands are presented in C(i+3) and accumulated at edge E(i+3).
- While result_valid=1 and result_ready=0, result stays stable and rd_en=0.
- Handshake at edge Ek puts the block in IDLE in C(k+1). A new start is accepted no earlier than that cycle, so there is 1 idle cycle minimum between jobs.
- Reset values: busy=0, rd_en=0, addr_a=0, addr_b=0, mac_ce=0, mac_a=0, mac_b=0, result_valid=0, d_vld=0, state=IDLE. mac_rst=1 while rst=1.
- rst mid-operation (any state) returns the block to IDLE on the next edge. The partial sum is discarded and no result_valid is produced.
- len=2^addrWidth reads every address exactly once, wrapping from base.

## Test plan
- len=3, A={1,2,3}, B={4,5,6} -> result_valid in C6, result=32, rd_en high exactly C2..C4, addr_a=base_a..base_a+2.
- len=0 -> result_valid in C3, result=0, rd_en never asserted.
- dataWidth=16, len=2, A={0x8000,0x0100}, B={2,0x0100} -> result=0x0000 (wrap), no other side effects.
- base_a=0xFE, len=4 -> addr_a sequence 0xFE, 0xFF, 0x00, 0x01.
- result_ready held low 5 cycles after result_valid -> result and mac_out unchanged. A start pulse during DONE is ignored. After ready, a second job (len=1, 7*3) returns 21.
- rst=1 in the middle of RUN -> next cycle IDLE, busy=0, result_valid=0. A subsequent job returns its correct sum with no residue from the previous one.

Source files
------------

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: streams operand pairs from two sync-read memories into an
// external registered MAC and presents the accumulated sum on a valid/ready port.
module mac_dot_ctrl #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned addrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrWidth:0]   len,
  input  logic [addrWidth-1:0] base_a,
  input  logic [addrWidth-1:0] base_b,
  output logic                 busy,
  output logic                 rd_en,
  output logic [addrWidth-1:0] addr_a,
  output logic [addrWidth-1:0] addr_b,
  input  logic [dataWidth-1:0] rdata_a,
  input  logic [dataWidth-1:0] rdata_b,
  output logic                 mac_rst,
  output logic                 mac_ce,
  output logic [dataWidth-1:0] mac_a,
  output logic [dataWidth-1:0] mac_b,
  output logic [dataWidth-1:0] mac_tmp,
  input  logic [dataWidth-1:0] mac_out,
  output logic [dataWidth-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready
);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StFlush, StDone} state_e;

  state_e               state_q, state_d;
  logic [addrWidth:0]   len_q;
  logic [addrWidth:0]   idx_q, idx_d;
  logic [addrWidth-1:0] base_a_q, base_b_q;
  logic                 d_vld_q;
  logic                 latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      d_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_vld_q <= rd_en;
      if (latch) begin
        len_q    <= len;
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          latch   = 1'b1;
          idx_d   = '0;
          state_d = StClear;
        end
      end
      StClear: state_d = (len_q != '0) ? StRun : StFlush;
      StRun: begin
        rd_en = 1'b1;
        idx_d = idx_q + (addrWidth + 1)'(1);
        // idx is one bit wider than an address so len = 2^addrWidth terminates
        if (idx_q == len_q - (addrWidth + 1)'(1)) state_d = StFlush;
      end
      StFlush: state_d = StDone;
      StDone:  if (result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign addr_a = base_a_q + idx_q[addrWidth-1:0];
  assign addr_b = base_b_q + idx_q[addrWidth-1:0];

  // Zero operands make the MAC hold its sum, since it has no enable of its own
  assign mac_ce  = d_vld_q;
  assign mac_a   = d_vld_q ? rdata_a : '0;
  assign mac_b   = d_vld_q ? rdata_b : '0;
  assign mac_tmp = mac_out;
  assign mac_rst = rst | (state_q == StClear);

  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = mac_out;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Bench for mac_dot_ctrl: models the operand memories and MAC, compares against a
// plain arithmetic dot-product reference.
module tb_mac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  base_a, base_b;
  logic        busy, rd_en;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] rdata_a, rdata_b;
  logic        mac_rst, mac_ce;
  logic [15:0] mac_a, mac_b, mac_tmp, mac_out;
  logic [15:0] result;
  logic        result_valid, result_ready;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_dot_ctrl #(.dataWidth(16), .addrWidth(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .busy(busy), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .mac_rst(mac_rst), .mac_ce(mac_ce),
    .mac_a(mac_a), .mac_b(mac_b), .mac_tmp(mac_tmp), .mac_out(mac_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  // Operand memories: one-cycle synchronous read
  always @(posedge clk) begin
    if (rd_en) begin
      rdata_a <= mem_a[addr_a];
      rdata_b <= mem_b[addr_b];
    end
  end

  // External MAC: data_out <= a*b + tmp, synchronous clear
  always @(posedge clk) begin
    if (mac_rst) mac_out <= 16'h0;
    else         mac_out <= 16'(mac_a * mac_b + mac_tmp);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_dot(input int n, input logic [7:0] ba,
                                          input logic [7:0] bb);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < n; i++) s = s + mem_a[8'(ba + i)] * mem_b[8'(bb + i)];
    return s[15:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from an idle cycle; hold = cycles with ready low in DONE,
  // poke = pulse start during DONE (must be ignored)
  task automatic do_job(input int n, input logic [7:0] ba, input logic [7:0] bb,
                        input int hold, input bit poke);
    logic [15:0] exp;
    logic [7:0]  ea, eb;
    bit          rd_exp, ce_exp;
    exp    = ref_dot(n, ba, bb);
    start  = 1'b1;
    len    = 9'(n);
    base_a = ba;
    base_b = bb;
    tick();
    start  = 1'b0;
    len    = 9'($urandom);
    base_a = 8'($urandom);
    base_b = 8'($urandom);
    for (int k = 1; k < n + 3; k++) begin
      rd_exp = (k >= 2) && (k <= n + 1);
      ce_exp = (k >= 3) && (k <= n + 2);
      check("busy_run", busy, 1);
      check("rd_en", rd_en, rd_exp);
      check("mac_ce", mac_ce, ce_exp);
      check("mac_rst", mac_rst, k == 1);
      if (rd_exp) begin
        ea = 8'(ba + k - 2);
        eb = 8'(bb + k - 2);
        check("addr_a", addr_a, ea);
        check("addr_b", addr_b, eb);
      end
      check("valid_early", result_valid, 0);
      tick();
    end
    check("valid", result_valid, 1);
    check("result", result, exp);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        start = 1'b1;
        len   = 9'd5;
      end
      tick();
      start = 1'b0;
      check("hold_valid", result_valid, 1);
      check("hold_result", result, exp);
      check("hold_mac_out", mac_out, exp);
      check("hold_rd_en", rd_en, 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", result_valid, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    len          = '0;
    base_a       = '0;
    base_b       = '0;
    result_ready = 1'b0;
    fill_random();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_mac_ce", mac_ce, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_valid", result_valid, 0);
    check("rst_mac_rst", mac_rst, 1);
    rst = 1'b0;
    tick();
    check("mac_rst_off", mac_rst, 0);

    // Directed: {1,2,3}.{4,5,6} = 32
    mem_a[10] = 16'd1; mem_a[11] = 16'd2; mem_a[12] = 16'd3;
    mem_b[20] = 16'd4; mem_b[21] = 16'd5; mem_b[22] = 16'd6;
    check("ref_32", ref_dot(3, 8'd10, 8'd20), 32);
    do_job(3, 8'd10, 8'd20, 0, 0);

    do_job(0, 8'd33, 8'd44, 0, 0);

    // Modular wrap of the accumulator
    mem_a[50] = 16'h8000; mem_a[51] = 16'h0100;
    mem_b[60] = 16'h0002; mem_b[61] = 16'h0100;
    do_job(2, 8'd50, 8'd60, 0, 0);

    // Address wrap
    do_job(4, 8'hFE, 8'hFD, 0, 0);

    // Back-pressure, ignored start in DONE, then a second job
    do_job(6, 8'd100, 8'd7, 5, 1);
    mem_a[3] = 16'd7; mem_b[4] = 16'd3;
    check("ref_21", ref_dot(1, 8'd3, 8'd4), 21);
    do_job(1, 8'd3, 8'd4, 0, 0);

    // Reset in the middle of RUN
    start = 1'b1; len = 9'd10; base_a = 8'd0; base_b = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_rd_en", rd_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_valid", result_valid, 0);
    end
    do_job(5, 8'd0, 8'd0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      fill_random();
      do_job(int'($urandom_range(0, 24)), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end

    // Full address space
    fill_random();
    do_job(256, 8'($urandom), 8'($urandom), 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
